adc_spi_responder: RTL
======================

Name: adc_spi_responder

Overview:
- Slave-side model of the ADC serial configuration port: the responder end of the adc_sclk/adc_sen/adc_mosi/adc_miso link driven by the ad_fun SPI master.
- Uses:
  - loopback and bring-up target on spare FMC pins;
  - synthesizable bench partner for the configuration master.
- Decodes 24-bit command frames into a local 16-bit register file and returns register contents on reads.
- Runs entirely in the clk10m domain; the SPI inputs are oversampled, not used as clocks.

Parameters:
- ADDR_W, 7, register address width; the register file has 2**ADDR_W entries.
- SYNC_STAGES, 2, synchronizer depth on the sclk, sen and mosi inputs (minimum 2).
- SOFT_RST_ADDR, 0, address whose data bit 0 triggers the soft reset.

Ports:
- clk10m, in, 1, 10 MHz system clock.
- sysrst_nr0, in, 1, asynchronous active-low reset (sys_rst_n & clk10m_locked).
- spi_sclk, in, 1, serial clock from the master. CPOL=0. Period ≥ 8 clk10m cycles.
- spi_sen, in, 1, active-low frame enable.
- spi_mosi, in, 1, serial data in, MSB first.
- spi_miso, out, 1, serial read data.
- spi_miso_oe, out, 1, high while spi_miso is being driven (read data phase).
- wr_valid, out, 1, one-cycle pulse when a write commits.
- wr_addr, out, ADDR_W, address of the committed write.
- wr_data, out, 16, data of the committed write.
- lcl_addr, in, ADDR_W, local read-back address.
- lcl_data, out, 16, register contents at lcl_addr, registered (1-cycle latency).
- frame_err, out, 1, one-cycle pulse on a malformed frame.
- frame_cnt, out, 16, count of good frames; wraps 0xFFFF→0.

Behaviour:
- Reset (sysrst_nr0 low), all values zero:
  - outputs: spi_miso, spi_miso_oe, wr_valid, wr_addr, wr_data, lcl_data, frame_err, frame_cnt;
  - all registers, state IDLE, bit counter.
  - Synchronizer flops reset to sclk=0, sen=1, mosi=0.
  - Reset asserted mid-frame aborts the frame silently (no frame_err).
- Input conditioning:
  - SYNC_STAGES flops on each input, plus one history flop per signal for edge detect.
  - Edge events (sclk rise, sclk fall, sen rise, sen fall) are single-cycle strobes.
- Frame format, 24 bits, MSB first:
  - bit 23 = R/W (1 = read);
  - bits 22:16 = address (low ADDR_W bits used, upper address bits ignored);
  - bits 15:0 = data.
  - The master shifts on its falling edge; mosi is sampled on the synchronized sclk rise.
- FSM:
  - IDLE → CMD on sen fall; clear bit counter and shift register.
  - CMD: shift mosi on each sclk rise. After the 8th rise, latch R/W and address, then go to DATA.
    - On a read, load out_sh ← reg[addr] in the same cycle.
    - spi_miso = reg[addr][15] and spi_miso_oe = 1 from the next cycle.
  - DATA: shift on each sclk rise.
    - Read: on each sclk fall, out_sh shifts left and spi_miso = new out_sh[15]. 16 bits are returned MSB first, sampled by the master on rises 9..24.
    - After the 24th rise, go to DONE.
  - DONE, write: in the cycle entering DONE, reg[addr] ← data, wr_valid = 1, wr_addr/wr_data are updated and hold until the next write.
    - If addr == SOFT_RST_ADDR and data[0] = 1, all registers clear to 0 in the following cycle instead of retaining data. wr_valid still pulses with the written data.
  - DONE → IDLE on sen rise: frame_cnt++ and spi_miso_oe = 0.
- Errors (frame_err pulses 1 cycle, state → IDLE, no register write, frame_cnt unchanged):
  - sen rise while in CMD or DATA (short frame), except a sen rise in CMD with zero bits received, which is silent;
  - any sclk rise while in DONE (long frame); the frame is marked bad and the pulse fires at that rise.
- Simultaneous events:
  - sen rise in the same cycle as the 24th sclk rise counts as a complete frame: commit, then IDLE.
  - sclk edges while sen is high are ignored.
- Reads do not modify registers.
- lcl_data reflects a write one cycle after wr_valid.

Test Plan:
- Write frame 0x05A5C3 (W, addr 0x05, data 0xA5C3), sclk period 10 cycles → wr_valid 1 cycle, wr_addr=0x05, wr_data=0xA5C3; lcl_addr=5 gives 0xA5C3; frame_cnt=1.
- Read frame 0x850000 after the previous write → miso bits on rises 9..24 = 0xA5C3; spi_miso_oe high from after rise 8 until sen rise; no wr_valid; frame_cnt=2.
- Short frame: sen rises after 12 bits of write 0x0A1234 → frame_err pulse; reg[0x0A] stays 0; frame_cnt unchanged.
- Long frame: 25 clocks with write 0x0B00FF → frame_err at the 25th rise. The write at bit 24 has already committed, so reg[0x0B]=0x00FF; frame_cnt unchanged.
- Soft reset: write regs 3=0x1111 and 4=0x2222, then write 0x000001 → all registers read 0; wr_valid pulse with addr 0, data 0x0001.
- Mid-frame async reset: drop sysrst_nr0 at bit 10 of a write to 0x07 → all outputs 0, no frame_err. The next valid read of 0x07 returns 0x0000.

Source files
------------

// File: rtl/adc_spi_responder.sv
// rtl/adc_spi_responder.sv - SPI configuration-port responder with 16-bit register file
// Decodes 24-bit R/W frames oversampled in the clk10m domain.
module adc_spi_responder #(
    parameter int ADDR_W        = 7,
    parameter int SYNC_STAGES   = 2,
    parameter int SOFT_RST_ADDR = 0
) (
    input  logic              clk10m,
    input  logic              sysrst_nr0,
    input  logic              spi_sclk,
    input  logic              spi_sen,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic              wr_valid,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    input  logic [ADDR_W-1:0] lcl_addr,
    output logic [15:0]       lcl_data,
    output logic              frame_err,
    output logic [15:0]       frame_cnt
);
    localparam int NREG = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] SOFT_ADDR = SOFT_RST_ADDR[ADDR_W-1:0];

    typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q, sen_sync_q, mosi_sync_q;
    logic                   sclk_h_q, sen_h_q;
    logic                   sclk_s, sen_s, mosi_s;
    logic                   sclk_rise, sclk_fall, sen_rise, sen_fall;

    state_t              state_q, state_d;
    logic [4:0]          bit_cnt_q, bit_cnt_d;
    logic [14:0]         in_sh_q, in_sh_d;
    logic                rw_q, rw_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [15:0]         out_sh_q, out_sh_d;
    logic                oe_q, oe_d;
    logic                wr_valid_q, wr_valid_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [15:0]         wr_data_q, wr_data_d;
    logic                err_q, err_d;
    logic [15:0]         cnt_q, cnt_d;
    logic                soft_q, soft_d;
    logic [15:0]         lcl_data_q;
    logic                reg_we;
    logic [15:0]         regs_q [NREG];
    logic [7:0]          cmd8;
    logic [15:0]         frame_word;

    always_ff @(posedge clk10m or negedge sysrst_nr0) begin
        if (!sysrst_nr0) begin
            sclk_sync_q <= '0;
            sen_sync_q  <= '1;
            mosi_sync_q <= '0;
            sclk_h_q    <= 1'b0;
            sen_h_q     <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
            sen_sync_q  <= {sen_sync_q[SYNC_STAGES-2:0], spi_sen};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
            sclk_h_q    <= sclk_s;
            sen_h_q     <= sen_s;
        end
    end

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign sen_s  = sen_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    // sclk is gated by the previous sen so a 24th rise coinciding with sen rise still counts
    assign sclk_rise = sclk_s & ~sclk_h_q & ~sen_h_q;
    assign sclk_fall = ~sclk_s & sclk_h_q & ~sen_h_q;
    assign sen_rise  = sen_s & ~sen_h_q;
    assign sen_fall  = ~sen_s & sen_h_q;

    assign cmd8       = {in_sh_q[6:0], mosi_s};
    assign frame_word = {in_sh_q, mosi_s};

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        in_sh_d    = in_sh_q;
        rw_d       = rw_q;
        addr_d     = addr_q;
        out_sh_d   = out_sh_q;
        oe_d       = oe_q;
        wr_valid_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        err_d      = 1'b0;
        cnt_d      = cnt_q;
        soft_d     = 1'b0;
        reg_we     = 1'b0;
        case (state_q)
            IDLE: begin
                if (sen_fall) begin
                    state_d   = CMD;
                    bit_cnt_d = '0;
                    in_sh_d   = '0;
                    out_sh_d  = '0;
                end
            end
            CMD: begin
                if (sen_rise) begin
                    state_d = IDLE;
                    err_d   = (bit_cnt_q != 5'd0);
                end else if (sclk_rise) begin
                    in_sh_d   = {in_sh_q[13:0], mosi_s};
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd7) begin
                        state_d = DATA;
                        rw_d    = cmd8[7];
                        addr_d  = cmd8[ADDR_W-1:0];
                        if (cmd8[7]) begin
                            out_sh_d = regs_q[cmd8[ADDR_W-1:0]];
                            oe_d     = 1'b1;
                        end
                    end
                end
            end
            DATA: begin
                if (sclk_rise && bit_cnt_q == 5'd23) begin
                    bit_cnt_d = 5'd24;
                    if (!rw_q) begin
                        reg_we     = 1'b1;
                        wr_valid_d = 1'b1;
                        wr_addr_d  = addr_q;
                        wr_data_d  = frame_word;
                        soft_d     = (addr_q == SOFT_ADDR) && frame_word[0];
                    end
                    if (sen_rise) begin
                        state_d  = IDLE;
                        cnt_d    = cnt_q + 16'd1;
                        oe_d     = 1'b0;
                        out_sh_d = '0;
                    end else begin
                        state_d = DONE;
                    end
                end else if (sen_rise) begin
                    state_d  = IDLE;
                    err_d    = 1'b1;
                    oe_d     = 1'b0;
                    out_sh_d = '0;
                end else if (sclk_rise) begin
                    in_sh_d   = {in_sh_q[13:0], mosi_s};
                    bit_cnt_d = bit_cnt_q + 5'd1;
                end else if (sclk_fall && rw_q && bit_cnt_q >= 5'd9) begin
                    // the fall after rise 8 is skipped so bit 15 is still on the wire at rise 9
                    out_sh_d = {out_sh_q[14:0], 1'b0};
                end
            end
            DONE: begin
                if (sclk_rise) begin
                    state_d  = IDLE;
                    err_d    = 1'b1;
                    oe_d     = 1'b0;
                    out_sh_d = '0;
                end else if (sen_rise) begin
                    state_d  = IDLE;
                    cnt_d    = cnt_q + 16'd1;
                    oe_d     = 1'b0;
                    out_sh_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk10m or negedge sysrst_nr0) begin
        if (!sysrst_nr0) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            in_sh_q    <= '0;
            rw_q       <= 1'b0;
            addr_q     <= '0;
            out_sh_q   <= '0;
            oe_q       <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
            soft_q     <= 1'b0;
            lcl_data_q <= '0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            in_sh_q    <= in_sh_d;
            rw_q       <= rw_d;
            addr_q     <= addr_d;
            out_sh_q   <= out_sh_d;
            oe_q       <= oe_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
            soft_q     <= soft_d;
            lcl_data_q <= regs_q[lcl_addr];
        end
    end

    always_ff @(posedge clk10m or negedge sysrst_nr0) begin
        if (!sysrst_nr0) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else if (soft_q) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else if (reg_we) begin
            regs_q[addr_q] <= frame_word;
        end
    end

    assign spi_miso    = out_sh_q[15];
    assign spi_miso_oe = oe_q;
    assign wr_valid    = wr_valid_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign lcl_data    = lcl_data_q;
    assign frame_err   = err_q;
    assign frame_cnt   = cnt_q;
endmodule
